// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs, digit width, update-flag states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package seg_pkg;

    localparam int BCD_W = 4;

    // Glyphs are {CG,CF,CE,CD,CC,CB,CA}, active-low (0 = segment lit).
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Update path: a staged value is either absent or waiting for the frame boundary.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } upd_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment glyph; non-decimal nibbles render as a dash.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: bcd (4-bit digit in), seg (7-bit {CG..CA} glyph out, active-low).
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode seven-segment driver; staged BCD updates commit only at frame boundaries.
// Latency: AN/SEG/DP registered, 1 cycle behind idx/disp_reg; bcd_valid to display <= one frame + 1 cycle.
// Backpressure: none; bcd_valid always accepted, last strobe before a commit wins.
// Ports: CLK100MHZ, CPU_RESETN (sync, active-low); bcd_in/dp_in/bcd_valid staged input;
//        AN (active-low anodes), SEG {CG..CA} and DP (active-low cathodes); upd_pending, frame_done status.
// Optional: define SEGMUX_LZ_BLANK_EN for leading-zero blanking (digit 0 never blanked).
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                        CLK100MHZ,
    input  logic                        CPU_RESETN,
    input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        bcd_valid,
    output logic [NUM_DIGITS-1:0]       AN,
    output logic [6:0]                  SEG,
    output logic                        DP,
    output logic                        upd_pending,
    output logic                        frame_done
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic [IDX_W-1:0]  idx;
    logic              tick;
    logic              commit;

    logic [NUM_DIGITS-1:0][BCD_W-1:0] pend_bcd;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] disp_bcd;
    logic [NUM_DIGITS-1:0]            pend_dp;
    logic [NUM_DIGITS-1:0]            disp_dp;

    upd_state_t upd_state;
    upd_state_t upd_next;

    logic [6:0] glyph;
    logic       blank;

    assign tick   = (tick_cnt == TICK_LAST);
    assign commit = tick && (idx == IDX_LAST);

    // Scan loop: slot counter and digit index.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            tick_cnt <= '0;
            idx      <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Update flag state register.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            upd_state <= IDLE;
        end else begin
            upd_state <= upd_next;
        end
    end

    // A strobe on the commit cycle bypasses straight to disp, so it never raises the flag.
    always_comb begin
        upd_next = upd_state;
        case (upd_state)
            IDLE:    if (bcd_valid && !commit) upd_next = PENDING;
            PENDING: if (commit)               upd_next = IDLE;
            default: upd_next = IDLE;
        endcase
    end

    assign upd_pending = (upd_state == PENDING);

    // Staging and committed value registers.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            pend_bcd   <= '0;
            pend_dp    <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit;
            if (bcd_valid && !commit) begin
                pend_bcd <= bcd_in;
                pend_dp  <= dp_in;
            end
            if (commit) begin
                if (bcd_valid) begin
                    disp_bcd <= bcd_in;
                    disp_dp  <= dp_in;
                end else if (upd_state == PENDING) begin
                    disp_bcd <= pend_bcd;
                    disp_dp  <= pend_dp;
                end
            end
        end
    end

    bcd_to_7seg u_dec (
        .bcd (disp_bcd[idx]),
        .seg (glyph)
    );

`ifdef SEGMUX_LZ_BLANK_EN
    // zero_from[i] = digits i..top of the committed value are all zero.
    logic [NUM_DIGITS-1:0] zero_from;

    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (disp_bcd[NUM_DIGITS-1] == '0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (disp_bcd[i] == '0);
        end
    end

    assign blank = (idx != '0) && zero_from[idx];
`else
    assign blank = 1'b0;
`endif

    // Output registers: present the digit selected by the current idx one edge later.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            AN  <= '1;
            SEG <= SEG_OFF;
            DP  <= 1'b1;
        end else if (blank) begin
            AN  <= '1;
            SEG <= SEG_OFF;
            DP  <= 1'b1;
        end else begin
            AN  <= ~(NUM_DIGITS'(1) << idx);
            SEG <= glyph;
            DP  <= ~disp_dp[idx];
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux at NUM_DIGITS=2, REFRESH_DIV=4 (8-cycle frame).
// Inputs change and outputs are sampled on the falling edge.
// Blanking expectations follow SEGMUX_LZ_BLANK_EN when defined.
module tb_seg_display_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bcd_in;
    logic [1:0] dp_in;
    logic       bcd_valid;
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       upd_pending;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

`ifdef SEGMUX_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    // Digit-1 slot when the upper digit is zero.
    localparam logic [1:0] AN_D1_ZERO  = LZ ? 2'b11 : 2'b01;
    localparam logic [6:0] SEG_D1_ZERO = LZ ? 7'b1111111 : 7'b1000000;

    always #5 clk = ~clk;

    seg_display_mux #(
        .NUM_DIGITS  (2),
        .REFRESH_DIV (4)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .bcd_valid   (bcd_valid),
        .AN          (an),
        .SEG         (seg),
        .DP          (dp),
        .upd_pending (upd_pending),
        .frame_done  (frame_done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic [1:0] e_an, input logic [6:0] e_seg,
                            input logic e_dp);
        chk({tag, "_an"},  8'(an),  8'(e_an));
        chk({tag, "_seg"}, 8'(seg), 8'(e_seg));
        chk({tag, "_dp"},  8'(dp),  8'(e_dp));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the falling edge right after the next commit edge (bounded).
    task automatic wait_frame(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 24 && !seen; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        chk(tag, 8'(seen), 8'h01);
    endtask

    // Issue a one-cycle strobe starting at the current falling edge; returns one edge later.
    task automatic strobe(input logic [7:0] b, input logic [1:0] d);
        bcd_in    = b;
        dp_in     = d;
        bcd_valid = 1'b1;
        cyc(1);
        bcd_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bcd_in    = '0;
        dp_in     = '0;
        bcd_valid = 1'b0;

        // Reset state.
        cyc(3);
        chk_slot("rst", 2'b11, 7'h7F, 1'b1);
        chk("rst_pend",  8'(upd_pending), 8'h00);
        chk("rst_frame", 8'(frame_done),  8'h00);

        // First edge after release drives digit 0 with the cleared value.
        rst_n = 1'b1;
        cyc(1);
        chk_slot("first", 2'b10, 7'b1000000, 1'b1);

        // 8'h15, dp=01: pending until commit, then 5/dp on digit 0, 1 on digit 1.
        wait_frame("s1_sync");
        strobe(8'h15, 2'b01);
        chk("s1_pend_a", 8'(upd_pending), 8'h01);
        cyc(6);
        chk("s1_pend_b", 8'(upd_pending), 8'h01);
        chk("s1_nofd",   8'(frame_done),  8'h00);
        cyc(1);
        chk("s1_pend_c", 8'(upd_pending), 8'h00);
        chk("s1_fd",     8'(frame_done),  8'h01);
        cyc(1);
        chk_slot("s1_d0", 2'b10, 7'b0010010, 1'b0);
        cyc(4);
        chk_slot("s1_d1", 2'b01, 7'b1111001, 1'b1);
        cyc(2);
        chk("s1_fd_lo", 8'(frame_done), 8'h00);
        cyc(1);
        chk("s1_fd_period", 8'(frame_done), 8'h01);

        // 8'h0A: dash on digit 0, zero on digit 1.
        wait_frame("s2_sync");
        strobe(8'h0A, 2'b00);
        cyc(8);
        chk_slot("s2_d0", 2'b10, 7'b0111111, 1'b1);
        cyc(4);
        chk_slot("s2_d1", AN_D1_ZERO, SEG_D1_ZERO, 1'b1);

        // 8'h12 then 8'h34 before the commit: only 3/4 appear.
        wait_frame("s3_sync");
        strobe(8'h12, 2'b00);
        cyc(1);
        strobe(8'h34, 2'b00);
        cyc(4);
        chk("s3_pend", 8'(upd_pending), 8'h01);
        cyc(1);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk_slot("s3_d0", 2'b10, 7'b0011001, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk_slot("s3_d1", 2'b01, 7'b0110000, 1'b1);
        end

        // 8'h27 on the commit cycle: bypass, flag never rises.
        wait_frame("s4_sync");
        cyc(7);
        chk("s4_pend_pre", 8'(upd_pending), 8'h00);
        bcd_in    = 8'h27;
        dp_in     = 2'b10;
        bcd_valid = 1'b1;
        cyc(1);
        bcd_valid = 1'b0;
        chk("s4_pend_at", 8'(upd_pending), 8'h00);
        chk("s4_fd",      8'(frame_done),  8'h01);
        cyc(1);
        chk("s4_pend_post", 8'(upd_pending), 8'h00);
        chk_slot("s4_d0", 2'b10, 7'b1111000, 1'b1);
        cyc(4);
        chk_slot("s4_d1", 2'b01, 7'b0100100, 1'b0);

        // 8'h07: upper zero digit blanked only when blanking is built in.
        wait_frame("s5_sync");
        strobe(8'h07, 2'b00);
        cyc(8);
        chk_slot("s5_d0", 2'b10, 7'b1111000, 1'b1);
        cyc(4);
        chk_slot("s5_d1", AN_D1_ZERO, SEG_D1_ZERO, 1'b1);

        // Reset while an update is pending discards it.
        wait_frame("s6_sync");
        strobe(8'h99, 2'b11);
        chk("s6_pend", 8'(upd_pending), 8'h01);
        rst_n = 1'b0;
        cyc(1);
        chk("s6_pend_rst", 8'(upd_pending), 8'h00);
        chk_slot("s6_rst", 2'b11, 7'h7F, 1'b1);
        rst_n = 1'b1;
        cyc(1);
        chk_slot("s6_first", 2'b10, 7'b1000000, 1'b1);
        wait_frame("s6_frame");
        cyc(1);
        chk("s6_pend_post", 8'(upd_pending), 8'h00);
        chk_slot("s6_d0", 2'b10, 7'b1000000, 1'b1);
        cyc(4);
        chk_slot("s6_d1", AN_D1_ZERO, SEG_D1_ZERO, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
